// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and op classification.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_ADC  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SBC  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_XNOR = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_ROL  = 4'b1010;
   localparam logic [3:0] OP_ROR  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Shifts, rotates and the multiplier take more than one cycle.
   function automatic logic is_iter(input logic [3:0] op);
      return (op == OP_MUL) || (op[3:2] == 2'b10);
   endfunction

   // Codes above MUL are unassigned.
   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU core: add/sub/logic ops and the single-bit shift/rotate step.
module alu_core #(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] res_o,
   output logic             c_out_o
);
   import alu_pkg::*;

   logic [WIDTH:0] sum_s;

   // Result and carry/borrow/shift-out for one operation or one shift step.
   always_comb begin
      sum_s   = {(WIDTH+1){1'b0}};
      res_o   = {WIDTH{1'b0}};
      c_out_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            sum_s   = {1'b0, a_i} + {1'b0, b_i};
            res_o   = sum_s[WIDTH-1:0];
            c_out_o = sum_s[WIDTH];
         end
         OP_ADC: begin
            sum_s   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
            res_o   = sum_s[WIDTH-1:0];
            c_out_o = sum_s[WIDTH];
         end
         OP_SUB: begin
            // Zero-extended difference: the top bit is the borrow.
            sum_s   = {1'b0, a_i} - {1'b0, b_i};
            res_o   = sum_s[WIDTH-1:0];
            c_out_o = sum_s[WIDTH];
         end
         OP_SBC: begin
            sum_s   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, c_i};
            res_o   = sum_s[WIDTH-1:0];
            c_out_o = sum_s[WIDTH];
         end
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_XOR:  res_o = a_i ^ b_i;
         OP_XNOR: res_o = ~(a_i ^ b_i);
         OP_SHL: begin
            res_o   = {a_i[WIDTH-2:0], 1'b0};
            c_out_o = a_i[WIDTH-1];
         end
         OP_SHR: begin
            res_o   = {1'b0, a_i[WIDTH-1:1]};
            c_out_o = a_i[0];
         end
         OP_ROL: res_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
         OP_ROR: res_o = {a_i[0], a_i[WIDTH-1:1]};
         default: begin
            res_o   = {WIDTH{1'b0}};
            c_out_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake, bit-serial shifts and shift-add multiply.
module seq_alu
   import alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int SC_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             start,
   input  logic [3:0]       aluOp,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cIn,
   input  logic [SC_W-1:0]  sc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] outHi,
   output logic             cOut,
   output logic             zero,
   output logic             err
);

   // One extra bit so the counter can hold WIDTH for the multiplier.
   localparam int CNT_W = SC_W + 1;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;       // shift operand, or multiplicand
   logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier, fills with product low half
   logic [WIDTH-1:0]   acc_q, acc_d;   // product high half
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               cout_q, cout_d;
   logic               zero_q, zero_d;
   logic               err_q, err_d;

   logic [3:0]         core_op_s;
   logic [WIDTH-1:0]   core_a_s;
   logic [WIDTH-1:0]   core_b_s;
   logic               core_c_s;
   logic [WIDTH-1:0]   core_res_s;
   logic               core_cout_s;

   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH-1:0]   mul_acc_s;
   logic [WIDTH-1:0]   mul_mq_s;

   // Steer the shared core: live inputs at accept, latched operands while iterating.
   always_comb begin
      core_op_s = aluOp;
      core_a_s  = in1;
      core_b_s  = in2;
      core_c_s  = cIn;
      if (state_q == RUN) begin
         if (op_q == OP_MUL) begin
            core_op_s = OP_ADD;
            core_a_s  = acc_q;
            core_b_s  = a_q;
            core_c_s  = 1'b0;
         end else begin
            core_op_s = op_q;
            core_a_s  = a_q;
            core_b_s  = {WIDTH{1'b0}};
            core_c_s  = 1'b0;
         end
      end else begin
         core_op_s = aluOp;
         core_a_s  = in1;
         core_b_s  = in2;
         core_c_s  = cIn;
      end
   end

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op_i    (core_op_s),
      .a_i     (core_a_s),
      .b_i     (core_b_s),
      .c_i     (core_c_s),
      .res_o   (core_res_s),
      .c_out_o (core_cout_s)
   );

   // One shift-add multiply step: conditionally add, then shift {acc,mq} right.
   always_comb begin
      if (mq_q[0]) begin
         mul_sum_s = {core_cout_s, core_res_s};
      end else begin
         mul_sum_s = {1'b0, acc_q};
      end
      mul_acc_s = mul_sum_s[WIDTH:1];
      mul_mq_s  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
   end

   // Next-state and next-result logic of the handshake FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      mq_d    = mq_q;
      acc_d   = acc_q;
      out_d   = out_q;
      hi_d    = hi_q;
      cout_d  = cout_q;
      zero_d  = zero_q;
      err_d   = err_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (!is_legal(aluOp)) begin
                  state_d = DONE;
                  out_d   = {WIDTH{1'b0}};
                  hi_d    = {WIDTH{1'b0}};
                  cout_d  = 1'b0;
                  zero_d  = 1'b0;
                  err_d   = 1'b1;
               end else if (aluOp == OP_MUL) begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(WIDTH);
                  op_d    = aluOp;
                  a_d     = in1;
                  mq_d    = in2;
                  acc_d   = {WIDTH{1'b0}};
               end else if (is_iter(aluOp)) begin
                  if (sc == {SC_W{1'b0}}) begin
                     // Zero-length shift: operand passes through, nothing shifted out.
                     state_d = DONE;
                     out_d   = in1;
                     hi_d    = {WIDTH{1'b0}};
                     cout_d  = 1'b0;
                     zero_d  = (in1 == {WIDTH{1'b0}});
                     err_d   = 1'b0;
                  end else begin
                     state_d = RUN;
                     cnt_d   = {1'b0, sc};
                     op_d    = aluOp;
                     a_d     = in1;
                  end
               end else begin
                  state_d = DONE;
                  out_d   = core_res_s;
                  hi_d    = {WIDTH{1'b0}};
                  cout_d  = core_cout_s;
                  zero_d  = (core_res_s == {WIDTH{1'b0}});
                  err_d   = 1'b0;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_acc_s;
               mq_d  = mul_mq_s;
            end else begin
               a_d   = core_res_s;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               err_d   = 1'b0;
               if (op_q == OP_MUL) begin
                  out_d  = mul_mq_s;
                  hi_d   = mul_acc_s;
                  cout_d = |mul_acc_s;
                  zero_d = (mul_mq_s == {WIDTH{1'b0}});
               end else begin
                  // Rotates report cOut = 0 from the core.
                  out_d  = core_res_s;
                  hi_d   = {WIDTH{1'b0}};
                  cout_d = core_cout_s;
                  zero_d = (core_res_s == {WIDTH{1'b0}});
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, working registers and result registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         op_q    <= 4'b0000;
         a_q     <= {WIDTH{1'b0}};
         mq_q    <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         out_q   <= {WIDTH{1'b0}};
         hi_q    <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         mq_q    <= mq_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         hi_q    <= hi_d;
         cout_q  <= cout_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign busy  = (state_q == RUN);
   assign done  = (state_q == DONE);
   assign out   = out_q;
   assign outHi = hi_q;
   assign cOut  = cout_q;
   assign zero  = zero_q;
   assign err   = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH = 8: expected results queued at accept, checked on done.
module tb_seq_alu;

   logic       clk;
   logic       rstN;
   logic       start;
   logic [3:0] aluOp;
   logic [7:0] in1;
   logic [7:0] in2;
   logic       cIn;
   logic [2:0] sc;
   logic       busy;
   logic       done;
   logic [7:0] out;
   logic [7:0] outHi;
   logic       cOut;
   logic       zero;
   logic       err;

   typedef struct {
      logic [7:0] out_v;
      logic [7:0] hi_v;
      logic       cout_v;
      logic       zero_v;
      logic       err_v;
      int         lat;
      int         acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   seq_alu #(.WIDTH(8)) dut (
      .clk   (clk),
      .rstN  (rstN),
      .start (start),
      .aluOp (aluOp),
      .in1   (in1),
      .in2   (in2),
      .cIn   (cIn),
      .sc    (sc),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .outHi (outHi),
      .cOut  (cOut),
      .zero  (zero),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_result(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour, written directly from the operation table.
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic ci, input logic [2:0] s);
      exp_t        e;
      logic [8:0]  t;
      logic [15:0] p;
      logic [7:0]  v;
      logic        c;
      e.out_v = 8'h00; e.hi_v = 8'h00; e.cout_v = 1'b0; e.zero_v = 1'b0; e.err_v = 1'b0;
      e.lat = 1; e.acc_cyc = 0;
      case (op)
         4'd0: begin t = {1'b0, a} + {1'b0, b};                  e.out_v = t[7:0]; e.cout_v = t[8]; end
         4'd1: begin t = {1'b0, a} + {1'b0, b} + {8'd0, ci};     e.out_v = t[7:0]; e.cout_v = t[8]; end
         4'd2: begin t = {1'b0, a} - {1'b0, b};                  e.out_v = t[7:0]; e.cout_v = t[8]; end
         4'd3: begin t = {1'b0, a} - {1'b0, b} - {8'd0, ci};     e.out_v = t[7:0]; e.cout_v = t[8]; end
         4'd4: e.out_v = a & b;
         4'd5: e.out_v = a | b;
         4'd6: e.out_v = a ^ b;
         4'd7: e.out_v = ~(a ^ b);
         4'd8, 4'd9, 4'd10, 4'd11: begin
            v = a; c = 1'b0;
            for (int i = 0; i < int'(s); i++) begin
               case (op)
                  4'd8:    begin c = v[7]; v = v << 1; end
                  4'd9:    begin c = v[0]; v = v >> 1; end
                  4'd10:   v = {v[6:0], v[7]};
                  default: v = {v[0], v[7:1]};
               endcase
            end
            e.out_v  = v;
            e.cout_v = (op == 4'd8 || op == 4'd9) ? c : 1'b0;
            e.lat    = int'(s) + 1;
         end
         4'd12: begin
            p = a * b;
            e.out_v = p[7:0]; e.hi_v = p[15:8]; e.cout_v = |p[15:8]; e.lat = 9;
         end
         default: begin
            e.err_v = 1'b1;
            return e;
         end
      endcase
      e.zero_v = (e.out_v == 8'h00);
      return e;
   endfunction

   // Present one op, queue its expectation once accepted, then scramble inputs.
   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [2:0] s);
      exp_t e;
      aluOp = op; in1 = a; in2 = b; cIn = ci; sc = s; start = 1'b1;
      e = model(op, a, b, ci, s);
      @(posedge clk); #1;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      start = 1'b0;
      in1 = 8'($urandom); in2 = 8'($urandom); cIn = 1'($urandom); sc = 3'($urandom);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         check_result("timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   // Compare every completed operation against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rstN && done) begin
         check_result("done_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_result("out",     32'(out),   32'(e.out_v));
            check_result("outHi",   32'(outHi), 32'(e.hi_v));
            check_result("cOut",    32'(cOut),  32'(e.cout_v));
            check_result("zero",    32'(zero),  32'(e.zero_v));
            check_result("err",     32'(err),   32'(e.err_v));
            check_result("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
            check_result("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rstN = 1'b0; start = 1'b0; aluOp = 4'd0; in1 = 8'h00; in2 = 8'h00; cIn = 1'b0; sc = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check_result("rst_busy",  32'(busy),  32'd0);
      check_result("rst_done",  32'(done),  32'd0);
      check_result("rst_out",   32'(out),   32'd0);
      check_result("rst_outHi", 32'(outHi), 32'd0);
      check_result("rst_flags", 32'({cOut, zero, err}), 32'd0);
      @(negedge clk); rstN = 1'b1;

      // Arithmetic and logic, including carry/borrow boundaries.
      drive(4'd0, 8'hFF, 8'h01, 1'b0, 3'd0); wait_empty();
      drive(4'd2, 8'h05, 8'h07, 1'b0, 3'd0); wait_empty();
      drive(4'd1, 8'hFE, 8'h01, 1'b1, 3'd0); wait_empty();
      drive(4'd3, 8'h00, 8'h00, 1'b1, 3'd0); wait_empty();
      drive(4'd7, 8'hA5, 8'h5A, 1'b0, 3'd0); wait_empty();

      // Shifts and rotates.
      drive(4'd8, 8'hA1, 8'h00, 1'b0, 3'd3);
      check_result("busy_shl", 32'(busy), 32'd1);
      wait_empty();
      drive(4'd9, 8'h81, 8'h00, 1'b0, 3'd0); wait_empty();
      drive(4'd11, 8'h01, 8'h00, 1'b0, 3'd1); wait_empty();
      drive(4'd10, 8'h81, 8'h00, 1'b0, 3'd4); wait_empty();
      drive(4'd9, 8'hC3, 8'h00, 1'b0, 3'd7); wait_empty();

      // Multiplier.
      drive(4'd12, 8'h0F, 8'h11, 1'b0, 3'd0); wait_empty();
      drive(4'd12, 8'hFF, 8'hFF, 1'b0, 3'd0); wait_empty();

      // Start during RUN must be ignored; operands are latched.
      drive(4'd12, 8'hD3, 8'h6B, 1'b0, 3'd0);
      @(posedge clk); #1;
      check_result("busy_mul", 32'(busy), 32'd1);
      aluOp = 4'd0; in1 = 8'h55; in2 = 8'hAA; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_empty();
      repeat (2) @(negedge clk);

      // Illegal codes.
      drive(4'd14, 8'h12, 8'h34, 1'b0, 3'd0); wait_empty();
      drive(4'd13, 8'h00, 8'h00, 1'b0, 3'd0); wait_empty();

      // Back-to-back single-cycle ops with start held high.
      for (int i = 0; i < 16; i++)
         drive(4'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
      wait_empty();

      // Reset in the middle of a multiply.
      drive(4'd12, 8'hFF, 8'hFF, 1'b0, 3'd0);
      repeat (3) @(posedge clk);
      #2;
      check_result("busy_before_rst", 32'(busy), 32'd1);
      sb_q.delete();
      rstN = 1'b0;
      #1;
      check_result("arst_busy",  32'(busy),  32'd0);
      check_result("arst_done",  32'(done),  32'd0);
      check_result("arst_out",   32'(out),   32'd0);
      check_result("arst_outHi", 32'(outHi), 32'd0);
      check_result("arst_flags", 32'({cOut, zero, err}), 32'd0);
      @(negedge clk); @(negedge clk);
      rstN = 1'b1;
      drive(4'd0, 8'h02, 8'h03, 1'b0, 3'd0); wait_empty();
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
